pong_game_ctrl: RTL



---
 rtl/pong_pkg.sv | 19 +
 rtl/bcd_score_ctr.sv | 33 +++
 rtl/pong_game_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong match controller: state encoding, BCD width, default tick counts.
package pong_pkg;

    localparam logic [1:0] S_NEWGAME = 2'd0;
    localparam logic [1:0] S_PLAY    = 2'd1;
    localparam logic [1:0] S_NEWBALL = 2'd2;
    localparam logic [1:0] S_OVER    = 2'd3;

    localparam int BCD_W                 = 8;
    localparam int DEF_WIN_SCORE         = 7;
    localparam int DEF_NEWBALL_TICKS     = 120;
    localparam int DEF_OVER_TICKS        = 180;

    // Two-digit BCD image of a small binary constant, evaluated at elaboration.
    function automatic logic [BCD_W-1:0] to_bcd(input int v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_score_ctr.sv
// Two-digit BCD score counter with synchronous clear, increment and saturation at 99.
// score_inc exposes the value an increment would produce so the caller can test for a win early.
module bcd_score_ctr
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] score,
    output logic [BCD_W-1:0] score_inc
);

    always_comb begin
        score_inc = score;
        if (score != 8'h99) begin
            if (score[3:0] == 4'd9)
                score_inc = {score[7:4] + 4'd1, 4'd0};
            else
                score_inc = {score[7:4], score[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            score <= '0;
        else if (clr)
            score <= '0;
        else if (inc)
            score <= score_inc;
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Match controller for pong: start/play/new-ball/game-over sequencing, BCD scores, rally count.
// Consumes the graphics stage's miss/hit flags and drives its gra_still freeze input.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE     = DEF_WIN_SCORE,
    parameter int NEWBALL_TICKS = DEF_NEWBALL_TICKS,
    parameter int OVER_TICKS    = DEF_OVER_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refresh_tick,
    input  logic [3:0]       btn,
    input  logic [1:0]       hit,
    input  logic             miss,
    input  logic             miss_side,
    output logic             gra_still,
    output logic [BCD_W-1:0] score_l,
    output logic [BCD_W-1:0] score_r,
    output logic [7:0]       rally,
    output logic             game_over,
    output logic             winner,
    output logic [1:0]       state_o
);

    localparam logic [BCD_W-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    logic [1:0]       state, state_next;
    logic             armed;
    logic [7:0]       timer;
    logic             hit_prev;
    logic [BCD_W-1:0] l_inc, r_inc;

    logic start, point, inc_l, inc_r, win, hit_rise;

    assign start    = (state == S_NEWGAME) && armed && (btn != 4'd0);
    assign point    = (state == S_PLAY) && miss;
    assign inc_l    = point && miss_side;
    assign inc_r    = point && !miss_side;
    assign win      = miss_side ? (l_inc == WIN_BCD) : (r_inc == WIN_BCD);
    assign hit_rise = (|hit) && !hit_prev;

    bcd_score_ctr u_score_l (
        .clk       (clk),
        .reset     (reset),
        .clr       (start),
        .inc       (inc_l),
        .score     (score_l),
        .score_inc (l_inc)
    );

    bcd_score_ctr u_score_r (
        .clk       (clk),
        .reset     (reset),
        .clr       (start),
        .inc       (inc_r),
        .score     (score_r),
        .score_inc (r_inc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_NEWGAME;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_NEWGAME: if (start)        state_next = S_PLAY;
            S_PLAY:    if (point)        state_next = win ? S_OVER : S_NEWBALL;
            S_NEWBALL: if (timer == 8'd0) state_next = S_PLAY;
            S_OVER:    if (timer == 8'd0) state_next = S_NEWGAME;
            default:                     state_next = S_NEWGAME;
        endcase
    end

    always_comb begin
        gra_still = (state != S_PLAY);
        game_over = (state == S_OVER);
        state_o   = state;
    end

    // Loading the timer takes priority over a coincident refresh tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed    <= 1'b0;
            timer    <= 8'd0;
            rally    <= 8'd0;
            hit_prev <= 1'b0;
            winner   <= 1'b0;
        end else begin
            hit_prev <= |hit;

            if (state == S_OVER && timer == 8'd0)
                armed <= 1'b0;
            else if (state == S_NEWGAME && btn == 4'd0)
                armed <= 1'b1;

            if (point)
                timer <= win ? 8'(OVER_TICKS) : 8'(NEWBALL_TICKS);
            else if (refresh_tick && timer != 8'd0)
                timer <= timer - 8'd1;

            if (start || point)
                rally <= 8'd0;
            else if (state == S_PLAY && hit_rise && rally != 8'hFF)
                rally <= rally + 8'd1;

            if (point && win)
                winner <= !miss_side;
        end
    end

endmodule
